// File: rtl/mux_pkg.sv
// mux_pkg: shared types and constants for the registered mux pipeline stage
package mux_pkg;
   localparam int MUX_DW = 32;
   typedef enum logic [1:0] {EMPTY, ONE, TWO} mux_state_e;
   function automatic int sel_w(input int m);
      return (m > 1) ? $clog2(m) : 1;
   endfunction
endpackage

// File: rtl/mux_n1.sv
// mux_n1: combinational N-bit M-to-1 selector; out-of-range indices fall back to source 0
module mux_n1 #(
   parameter int N = 32,
   parameter int M = 4,
   parameter int S = 2
) (
   input  logic [M-1:0][N-1:0] in_data,
   input  logic [S-1:0]        sel,
   output logic [N-1:0]        data,
   output logic                oob
);
   assign oob  = 32'(sel) >= M;
   assign data = oob ? in_data[0] : in_data[sel];
endmodule

// File: rtl/mux_pipe_reg.sv
// mux_pipe_reg: registered M-to-1 selector with valid/ready output stage
// MUX_PIPE_SKID_EN adds a skid entry so in_ready is registered and independent of out_ready.
module mux_pipe_reg
   import mux_pkg::*;
#(
   parameter int N = MUX_DW,
   parameter int M = 4,
   localparam int S = sel_w(M)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [M-1:0][N-1:0] in_data,
   input  logic [S-1:0]       sel,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               flush,
   output logic [N-1:0]       out_data,
   output logic [S-1:0]       out_sel,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               sel_err
);
   mux_state_e state_q, state_d;
   logic [N-1:0] out_data_q, out_data_d, mux_data;
   logic [S-1:0] out_sel_q, out_sel_d;
   logic sel_err_q, sel_err_d, oob, acc, cons;
`ifdef MUX_PIPE_SKID_EN
   logic [N-1:0] skid_data_q, skid_data_d;
   logic [S-1:0] skid_sel_q, skid_sel_d;
   logic in_ready_q;
`endif

   mux_n1 #(.N(N), .M(M), .S(S)) u_mux (
      .in_data(in_data),
      .sel(sel),
      .data(mux_data),
      .oob(oob)
   );

   assign out_valid = state_q != EMPTY;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;
   assign sel_err   = sel_err_q;
`ifdef MUX_PIPE_SKID_EN
   assign in_ready  = in_ready_q && !rst;
`else
   assign in_ready  = !rst && (!out_valid || out_ready);
`endif
   assign acc  = in_valid && in_ready && !flush;
   assign cons = out_valid && out_ready;

   always_comb begin
      state_d    = state_q;
      out_data_d = out_data_q;
      out_sel_d  = out_sel_q;
      sel_err_d  = sel_err_q || (acc && oob);
`ifdef MUX_PIPE_SKID_EN
      skid_data_d = skid_data_q;
      skid_sel_d  = skid_sel_q;
`endif
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: if (acc) begin
               state_d    = ONE;
               out_data_d = mux_data;
               out_sel_d  = sel;
            end
            ONE: if (acc && cons) begin
               out_data_d = mux_data;
               out_sel_d  = sel;
`ifdef MUX_PIPE_SKID_EN
            end else if (acc) begin
               state_d     = TWO;
               skid_data_d = mux_data;
               skid_sel_d  = sel;
`endif
            end else if (cons) begin
               state_d = EMPTY;
            end
`ifdef MUX_PIPE_SKID_EN
            TWO: if (cons) begin
               state_d    = ONE;
               out_data_d = skid_data_q;
               out_sel_d  = skid_sel_q;
            end
`endif
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         out_data_q <= '0;
         out_sel_q  <= '0;
         sel_err_q  <= 1'b0;
`ifdef MUX_PIPE_SKID_EN
         skid_data_q <= '0;
         skid_sel_q  <= '0;
         in_ready_q  <= 1'b1;
`endif
      end else begin
         state_q    <= state_d;
         out_data_q <= out_data_d;
         out_sel_q  <= out_sel_d;
         sel_err_q  <= sel_err_d;
`ifdef MUX_PIPE_SKID_EN
         skid_data_q <= skid_data_d;
         skid_sel_q  <= skid_sel_d;
         in_ready_q  <= state_d != TWO;
`endif
      end
   end
endmodule
